// File: rtl/ram_read_streamer.sv
// Streams sequential RAM reads for (address, length) commands as a valid/ready word stream.
// Read credits cover in-flight reads plus FIFO occupancy, so the RAM never has to stall.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready_o high
// ST_ISSUE | issuing reads while credit is available
// ST_DRAIN | all reads issued, waiting for in-flight and FIFO to empty
module ram_read_streamer #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  ram_read_en_o,
    output logic [ADDR_WIDTH-1:0] ram_address_o,
    input  logic [WIDTH-1:0]      ram_read_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WIDTH-1:0]      m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int SUM_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0] CREDITS  = SUM_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [INF_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LATENCY-1:0]    tag_v_q, tag_l_q;
    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;

    logic                  cmd_fire, issue, issue_last, push, pop, credit_ok;
    logic [SUM_W-1:0]      used;

    // Credit uses registered counts only, so a pop frees its slot one cycle later.
    assign used        = SUM_W'(inflight_q) + SUM_W'(count_q);
    assign credit_ok   = used < CREDITS;
    assign issue       = (state_q == ST_ISSUE) && credit_ok;
    assign issue_last  = issue && (remaining_q == LEN_WIDTH'(1));
    assign push        = tag_v_q[LATENCY-1];
    assign pop         = m_valid_o && m_ready_i;
    assign cmd_ready_o = (state_q == ST_IDLE) && !reset_i;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;

    assign ram_read_en_o = issue;
    assign ram_address_o = addr_q;
    assign m_valid_o     = (count_q != '0);
    assign m_data_o      = mem_q[rd_ptr_q];
    assign m_last_o      = m_valid_o && last_mem_q[rd_ptr_q];
    assign busy_o        = (state_q != ST_IDLE) || (inflight_q != '0) || (count_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !push) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!issue && push) begin
            inflight_d = inflight_q - INF_W'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (cmd_len_i != '0)) begin
                    state_d     = ST_ISSUE;
                    addr_d      = cmd_addr_i;
                    remaining_d = cmd_len_i;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight_d == '0) && (count_d == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
        end
    end

    // Clearing the tags on reset is what discards RAM data still in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_v_q <= '0;
            tag_l_q <= '0;
        end else begin
            tag_v_q[0] <= issue;
            tag_l_q[0] <= issue_last;
            for (int k = 1; k < LATENCY; k++) begin
                tag_v_q[k] <= tag_v_q[k-1];
                tag_l_q[k] <= tag_l_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_mem_q <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]      <= ram_read_data_i;
                last_mem_q[wr_ptr_q] <= tag_l_q[LATENCY-1];
                wr_ptr_q             <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && (count_q == CNT_FULL)));

endmodule

// File: tb/tb_ram_read_streamer.sv
// Bench for ram_read_streamer: two instances (LATENCY=1/FIFO_DEPTH=4 and LATENCY=3/FIFO_DEPTH=5)
// checked every cycle against a queue model of expected words, credits and arrival times.
module tb_ram_read_streamer;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid [2];
    logic [AW-1:0] cmd_addr  [2];
    logic [LW-1:0] cmd_len   [2];
    logic          m_ready   [2];
    wire           cmd_ready [2];
    wire           rd_en     [2];
    wire  [AW-1:0] rd_addr   [2];
    wire  [DW-1:0] rd_data   [2];
    wire           m_valid   [2];
    wire  [DW-1:0] m_data    [2];
    wire           m_last    [2];
    wire           busy      [2];

    logic [DW-1:0] ram_mem [1024];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    word_t         exp_q   [2][$];
    int            avail_q [2][$];
    int            to_issue [2];
    logic [AW-1:0] exp_addr [2];
    int cmd_cyc [2], first_rd [2], first_mv [2], last_cyc [2], busy_low [2];
    int reads [2], words [2], lasts [2];
    bit acc [2], rand_mode [2];
    int addr_log [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int FD  = (g == 0) ? 4 : 5;
        logic [DW-1:0] pipe [LAT];

        // RAM has no reset, so reads launched before a reset still return data.
        always @(posedge clk) begin
            if (rd_en[g]) pipe[0] <= ram_mem[rd_addr[g]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign rd_data[g] = pipe[LAT-1];

        ram_read_streamer #(
            .WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .LATENCY(LAT), .FIFO_DEPTH(FD)
        ) u_dut (
            .clk_i          (clk),
            .reset_i        (rst),
            .cmd_valid_i    (cmd_valid[g]),
            .cmd_ready_o    (cmd_ready[g]),
            .cmd_addr_i     (cmd_addr[g]),
            .cmd_len_i      (cmd_len[g]),
            .ram_read_en_o  (rd_en[g]),
            .ram_address_o  (rd_addr[g]),
            .ram_read_data_i(rd_data[g]),
            .m_valid_o      (m_valid[g]),
            .m_ready_i      (m_ready[g]),
            .m_data_o       (m_data[g]),
            .m_last_o       (m_last[g]),
            .busy_o         (busy[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int fd_of(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic check_cycle(input int i);
        int    n;
        bit    exp_rd, exp_mv;
        word_t w;
        if (rst) return;
        n = exp_q[i].size();
        chk($sformatf("cmd_ready[%0d]", i), 64'(cmd_ready[i]), 64'(n == 0));
        chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(n != 0));
        if (cmd_cyc[i] >= 0 && busy_low[i] < 0 && !busy[i] && cyc > cmd_cyc[i]) busy_low[i] = cyc;

        // A read may issue while unissued words remain and fewer than FIFO_DEPTH are outstanding.
        exp_rd = (to_issue[i] > 0) && (avail_q[i].size() < fd_of(i));
        chk($sformatf("read_en[%0d]", i), 64'(rd_en[i]), 64'(exp_rd));
        if (rd_en[i]) begin
            chk($sformatf("ram_address[%0d]", i), 64'(rd_addr[i]), 64'(exp_addr[i]));
            if (i == 0) addr_log.push_back(int'(rd_addr[i]));
            if (first_rd[i] < 0) first_rd[i] = cyc;
            reads[i]++;
            avail_q[i].push_back(cyc + lat_of(i) + 1);
            exp_addr[i] = exp_addr[i] + AW'(1);
            if (to_issue[i] > 0) to_issue[i]--;
        end

        exp_mv = (avail_q[i].size() > 0) && (avail_q[i][0] <= cyc);
        chk($sformatf("m_valid[%0d]", i), 64'(m_valid[i]), 64'(exp_mv));
        if (exp_mv && m_valid[i] && n > 0) begin
            chk($sformatf("m_data[%0d]", i), 64'(m_data[i]), 64'(exp_q[i][0].d));
            chk($sformatf("m_last[%0d]", i), 64'(m_last[i]), 64'(exp_q[i][0].l));
            if (first_mv[i] < 0) first_mv[i] = cyc;
            if (m_ready[i]) begin
                words[i]++;
                if (m_last[i]) begin
                    lasts[i]++;
                    last_cyc[i] = cyc;
                end
                void'(exp_q[i].pop_front());
                void'(avail_q[i].pop_front());
            end
        end

        if (cmd_valid[i] && cmd_ready[i]) begin
            acc[i]     = 1'b1;
            cmd_cyc[i] = cyc;
            if (cmd_len[i] != '0) exp_addr[i] = cmd_addr[i];
            to_issue[i] = int'(cmd_len[i]);
            for (int k = 0; k < int'(cmd_len[i]); k++) begin
                w.d = ram_mem[AW'(int'(cmd_addr[i]) + k)];
                w.l = (k == int'(cmd_len[i]) - 1);
                exp_q[i].push_back(w);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_cycle(0);
        check_cycle(1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (rand_mode[i]) m_ready[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic send_cmd(input int i, input int addr, input int len);
        cmd_cyc[i] = -1; first_rd[i] = -1; first_mv[i] = -1; last_cyc[i] = -1; busy_low[i] = -1;
        reads[i] = 0; words[i] = 0; lasts[i] = 0; acc[i] = 1'b0;
        if (i == 0) addr_log.delete();
        cmd_addr[i]  = AW'(addr);
        cmd_len[i]   = LW'(len);
        cmd_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !acc[i]; k++) step();
        cmd_valid[i] = 1'b0;
        chk("cmd accepted", 64'(acc[i]), 64'(1));
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k = 0;
        while (exp_q[i].size() != 0 && k < budget) begin
            step();
            k++;
        end
        chk("drain within budget", 64'(k < budget), 64'(1));
        step();
    endtask

    task automatic reset_outputs(input int i);
        chk("rst cmd_ready", 64'(cmd_ready[i]), 64'(0));
        chk("rst read_en", 64'(rd_en[i]), 64'(0));
        chk("rst ram_address", 64'(rd_addr[i]), 64'(0));
        chk("rst m_valid", 64'(m_valid[i]), 64'(0));
        chk("rst m_last", 64'(m_last[i]), 64'(0));
        chk("rst m_data", 64'(m_data[i]), 64'(0));
        chk("rst busy", 64'(busy[i]), 64'(0));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            avail_q[i].delete();
            to_issue[i] = 0;
            exp_addr[i] = '0;
        end
    endtask

    initial begin
        int k;
        int exp_a [4];
        exp_a = '{1022, 1023, 0, 1};
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_addr[i] = '0; cmd_len[i] = '0;
            m_ready[i] = 1'b1; rand_mode[i] = 1'b0; cmd_cyc[i] = -1;
            busy_low[i] = -1;
        end
        clear_model();
        for (int a = 0; a < 1024; a++) ram_mem[a] = $urandom;

        #2 rst = 1'b1;
        #1 reset_outputs(0);
        reset_outputs(1);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic command, timing pinned relative to the handshake cycle
        send_cmd(0, 5, 4);
        wait_idle(0, 50);
        chk("t1 first read offset", 64'(first_rd[0] - cmd_cyc[0]), 64'(1));
        chk("t1 first valid offset", 64'(first_mv[0] - cmd_cyc[0]), 64'(3));
        chk("t1 last offset", 64'(last_cyc[0] - cmd_cyc[0]), 64'(6));
        chk("t1 busy low offset", 64'(busy_low[0] - cmd_cyc[0]), 64'(7));
        chk("t1 words", 64'(words[0]), 64'(4));
        chk("t1 lasts", 64'(lasts[0]), 64'(1));

        // Address wrap
        send_cmd(0, 1022, 4);
        wait_idle(0, 50);
        chk("t2 address count", 64'(addr_log.size()), 64'(4));
        for (int j = 0; j < 4 && j < addr_log.size(); j++)
            chk($sformatf("t2 address %0d", j), 64'(addr_log[j]), 64'(exp_a[j]));

        // Backpressure: credits cap reads at FIFO_DEPTH
        m_ready[0] = 1'b0;
        send_cmd(0, 200, 8);
        repeat (20) step();
        chk("t3 reads while stalled", 64'(reads[0]), 64'(4));
        chk("t3 read_en low", 64'(rd_en[0]), 64'(0));
        chk("t3 m_valid held", 64'(m_valid[0]), 64'(1));
        chk("t3 m_data held", 64'(m_data[0]), 64'(ram_mem[200]));
        m_ready[0] = 1'b1;
        wait_idle(0, 50);
        chk("t3 words", 64'(words[0]), 64'(8));
        chk("t3 lasts", 64'(lasts[0]), 64'(1));

        // Zero-length command
        send_cmd(0, 33, 0);
        repeat (8) step();
        chk("t4 reads", 64'(reads[0]), 64'(0));
        chk("t4 words", 64'(words[0]), 64'(0));
        chk("t4 cmd_ready", 64'(cmd_ready[0]), 64'(1));
        chk("t4 busy", 64'(busy[0]), 64'(0));

        // LATENCY=3 with random backpressure
        rand_mode[1] = 1'b1;
        send_cmd(1, int'($urandom_range(0, 1023)), 100);
        wait_idle(1, 2000);
        rand_mode[1] = 1'b0;
        m_ready[1] = 1'b1;
        chk("t5 words", 64'(words[1]), 64'(100));
        chk("t5 lasts", 64'(lasts[1]), 64'(1));

        // LATENCY=3 full throughput
        send_cmd(1, 1015, 16);
        wait_idle(1, 100);
        chk("t5b first valid offset", 64'(first_mv[1] - cmd_cyc[1]), 64'(5));
        chk("t5b last offset", 64'(last_cyc[1] - cmd_cyc[1]), 64'(20));
        chk("t5b words", 64'(words[1]), 64'(16));

        // Reset in the middle of a command
        send_cmd(0, 500, 10);
        k = 0;
        while (words[0] < 3 && k < 50) begin
            step();
            k++;
        end
        chk("t6 words before reset", 64'(words[0]), 64'(3));
        #2 rst = 1'b1;
        #1 reset_outputs(0);
        clear_model();
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        send_cmd(0, 0, 2);
        wait_idle(0, 50);
        chk("t6 words after reset", 64'(words[0]), 64'(2));
        chk("t6 lasts after reset", 64'(lasts[0]), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
